// File: rtl/nios_fprint_mem_copy_engine_pkg.sv
// Shared types and default geometry for the fingerprint-buffer memory copy engine.
package nios_fprint_copy_pkg;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 153600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_CAPT,
        ST_WR,
        ST_FIN
    } copy_state_t;

endpackage

// File: rtl/nios_fprint_mem_copy_engine_if.sv
// Single-port on-chip memory bus between the copy engine (master) and the RAM (slave).
interface nios_fprint_mem_copy_engine_if
    import nios_fprint_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic [DATA_W-1:0]   mem_readdata;

    modport master (
        output mem_address,
        output mem_byteenable,
        output mem_chipselect,
        output mem_write,
        output mem_writedata,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_byteenable,
        input  mem_chipselect,
        input  mem_write,
        input  mem_writedata,
        output mem_readdata
    );

endinterface

// File: rtl/nios_fprint_mem_copy_engine.sv
// Word-by-word ascending memory copy with running checksum and out-of-range abort.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; checksum/error hold the last result
// ST_RD_ADDR | read address for src_ptr on the bus
// ST_RD_CAPT | read data returning; captured into the write data register
// ST_WR      | write of captured word to dst_ptr; pointers advance
// ST_FIN     | one-cycle done pulse, then back to idle
module nios_fprint_mem_copy_engine
    import nios_fprint_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [ADDR_W-1:0]   length,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [DATA_W-1:0]   checksum,
    nios_fprint_mem_copy_engine_if.master mem
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

    copy_state_t       state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] src_nxt;
    logic [ADDR_W-1:0] dst_nxt;
    logic              cs_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cs_live;
    logic              wr_live;

    function automatic logic in_range(input logic [ADDR_W-1:0] ptr);
        return {1'b0, ptr} < DEPTH_L;
    endfunction

    assign src_nxt = src_ptr + ONE;
    assign dst_nxt = dst_ptr + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cs_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        checksum  <= '0;
                        src_ptr   <= src_base;
                        dst_ptr   <= dst_base;
                        remaining <= length;
                        if (length == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else if (!in_range(src_base)) begin
                            error <= 1'b1;
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            cs_q   <= 1'b1;
                            addr_q <= src_base;
                            state  <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    cs_q  <= 1'b0;
                    state <= ST_RD_CAPT;
                end
                ST_RD_CAPT: begin
                    // Destination is checked only now, so a bad dst costs one read but never a write.
                    if (!in_range(dst_ptr)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        wdata_q  <= mem.mem_readdata;
                        checksum <= checksum + mem.mem_readdata;
                        cs_q     <= 1'b1;
                        wr_q     <= 1'b1;
                        addr_q   <= dst_ptr;
                        state    <= ST_WR;
                    end
                end
                ST_WR: begin
                    cs_q      <= 1'b0;
                    wr_q      <= 1'b0;
                    src_ptr   <= src_nxt;
                    dst_ptr   <= dst_nxt;
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else if (!in_range(src_nxt)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        cs_q   <= 1'b1;
                        addr_q <= src_nxt;
                        state  <= ST_RD_ADDR;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    cs_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by reset so a write already on the bus is dropped in the reset cycle.
    assign cs_live            = cs_q & ~reset;
    assign wr_live            = wr_q & ~reset;
    assign mem.mem_chipselect = cs_live;
    assign mem.mem_write      = wr_live;
    assign mem.mem_byteenable = {(DATA_W/8){cs_live}};
    assign mem.mem_address    = addr_q;
    assign mem.mem_writedata  = wdata_q;

endmodule

// File: doc/nios_fprint_mem_copy_engine.md
NIOS_FPRINT_MEM_COPY_ENGINE -- requirements
Module: nios_fprint_mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 18, word-address width of the attached on-chip memory port.
REQ-002 Parameter DATA_W, default 32, memory data width; byteenable width is DATA_W/8.
REQ-003 Parameter DEPTH, default 153600, number of valid words in the attached memory.
REQ-004 One clock and one reset: clk is the single clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-008 src_base  in  ADDR_W  first source word address; sampled with start.
REQ-009 dst_base  in  ADDR_W  first destination word address; sampled with start.
REQ-010 length  in  ADDR_W  words to copy; sampled with start.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse at completion or abort.
REQ-013 error  out  1  sticky abort flag, cleared by the next accepted start.
REQ-014 checksum  out  DATA_W  modulo-2^DATA_W sum of all words written in the current or last copy.
REQ-015 mem_address  out  ADDR_W  word address to the memory.
REQ-016 mem_byteenable  out  DATA_W/8  all ones whenever mem_chipselect is high, else zero.
REQ-017 mem_chipselect  out  1  memory access strobe.
REQ-018 mem_write  out  1  write qualifier; high only together with mem_chipselect.
REQ-019 mem_writedata  out  DATA_W  write data.
REQ-020 mem_readdata  in  DATA_W  memory read data, valid the cycle after a read address is presented (unregistered output).

Function
REQ-021 FSM states: IDLE, RD_ADDR, RD_CAPT, WR, FIN; all transitions on clk rising edge.
REQ-022 IDLE: start=1 and length>0 -> latch src/dst/length, clear checksum and error, go RD_ADDR; start=1 and length=0 -> go FIN with no memory access.
REQ-023 RD_ADDR: drive mem_address=src_ptr, chipselect=1, write=0; go RD_CAPT.
REQ-024 RD_CAPT: chipselect=0; capture mem_readdata into data register at cycle end; go WR.
REQ-025 WR: drive mem_address=dst_ptr, chipselect=1, write=1, writedata=data register; checksum += data; increment src_ptr, dst_ptr, decrement remaining; remaining=1 -> FIN, else RD_ADDR.
REQ-026 FIN: done=1 for one cycle, busy=0 from the next cycle; go IDLE.
REQ-027 Throughput 3 cycles per word; start-accept to done pulse = 3*length+1 cycles; length=0 gives done on the cycle after start.
REQ-028 Pointers wrap modulo 2^ADDR_W; before each RD_ADDR/WR, any pointer >= DEPTH aborts: no access issued, error=1, go FIN.
REQ-029 Copy is strictly ascending; overlapping regions with dst>src propagate source data forward (defined, not corrected).
REQ-030 start while busy is ignored; src_base/dst_base/length changes while busy have no effect.
REQ-031 checksum and error hold their values in IDLE until the next accepted start.

Reset
REQ-032 reset forces IDLE within one cycle, including mid-copy; no write is issued in the reset cycle.
REQ-033 Reset values: busy=0, done=0, error=0, checksum=0, mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0.

Structure
REQ-034 Package nios_fprint_copy_pkg holds the FSM state enum and the default DEPTH/ADDR_W/DATA_W constants.
REQ-035 No sub-module; pointers, length counter and checksum accumulator are inline in the single module.

Verification
REQ-036 Bench memory model: 153600x32 single-port, 1-cycle unregistered read, byteenable honoured.
REQ-037 src=0x00010, dst=0x01000, length=4, words 0x11,0x22,0x33,0x44 -> dst holds same words, checksum=0xAA, done 13 cycles after start.
REQ-038 length=0 -> done pulse next cycle, mem_chipselect never high, checksum=0, error=0.
REQ-039 src=0x257FE, dst=0x00000, length=4 -> two words copied, abort at src=0x25800, error=1, done pulse, no third access.
REQ-040 Reset asserted in WR of word 3 of a 10-word copy -> next cycle IDLE, all outputs at reset values, words 4-10 untouched.
REQ-041 start re-pulsed every cycle during a 5-word copy -> single copy of 5 words, exactly one done pulse.
